// File: rtl/clk_div_gate_bank_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_bank_pkg
// Shared defaults and the per-channel state record for the clock divider bank.
//   NUM_CH_DEF  : default channel count
//   DIV_W_DEF   : default width of a half-period ratio field
//   DIV_W_MAX   : widest ratio field the state record can hold (DIV_W <= DIV_W_MAX)
//   ch_state_t  : one channel's architectural state
// -----------------------------------------------------------------------------
package clk_div_bank_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int DIV_W_DEF  = 8;
    localparam int DIV_W_MAX  = 16;

    // Ratio/counter fields are sized for the widest supported channel; narrower
    // channels zero-extend into them, so the upper bits stay constant zero.
    typedef struct packed {
        logic [DIV_W_MAX-1:0] active_ratio;
        logic [DIV_W_MAX-1:0] pending_ratio;
        logic                 pending_flag;
        logic [DIV_W_MAX-1:0] cnt;
        logic                 out_q;
        logic                 active;
    } ch_state_t;

endpackage

// File: rtl/clk_div_gate_bank_if.sv
// -----------------------------------------------------------------------------
// clk_div_gate_bank_if
// Control/status bundle of the clock divider bank.
//   div_ratio    : NUM_CH*DIV_W, channel c ratio at [c*DIV_W +: DIV_W]
//   div_load     : NUM_CH, one-cycle ratio capture request per channel
//   ch_enable    : NUM_CH, run level per channel
//   clock_output : NUM_CH, registered divided clocks
//   load_ack     : NUM_CH, pulse when a captured ratio takes effect
//   ch_active    : NUM_CH, channel is toggling
//   rise_strobe  : NUM_CH, only with CLK_DIV_BANK_EDGE_STROBE_EN defined
// master drives the controls, slave is the divider bank.
// -----------------------------------------------------------------------------
interface clk_div_gate_bank_if #(
    parameter int NUM_CH = clk_div_bank_pkg::NUM_CH_DEF,
    parameter int DIV_W  = clk_div_bank_pkg::DIV_W_DEF
);
    logic [NUM_CH*DIV_W-1:0] div_ratio;
    logic [NUM_CH-1:0]       div_load;
    logic [NUM_CH-1:0]       ch_enable;
    logic [NUM_CH-1:0]       clock_output;
    logic [NUM_CH-1:0]       load_ack;
    logic [NUM_CH-1:0]       ch_active;
`ifdef CLK_DIV_BANK_EDGE_STROBE_EN
    logic [NUM_CH-1:0]       rise_strobe;
`endif

    modport master (
        output div_ratio, div_load, ch_enable,
        input  clock_output, load_ack, ch_active
`ifdef CLK_DIV_BANK_EDGE_STROBE_EN
        , input rise_strobe
`endif
    );

    modport slave (
        input  div_ratio, div_load, ch_enable,
        output clock_output, load_ack, ch_active
`ifdef CLK_DIV_BANK_EDGE_STROBE_EN
        , output rise_strobe
`endif
    );
endinterface

// File: rtl/clk_div_gate_bank_channel.sv
// -----------------------------------------------------------------------------
// clk_div_channel
// One divider lane: 50% duty divide-by-2*(R+1), glitch-free enable/disable and
// ratio reload deferred to the falling toggle.
//   clk_i, rst_i : clock, synchronous active-high reset
//   ratio_i      : this lane's ratio slice
//   load_i       : capture ratio_i as the pending ratio
//   enable_i     : run level
//   clk_o        : divided clock (register)
//   ack_o        : pulse when the pending ratio becomes active
//   active_o     : lane is toggling
//   strobe_o     : with CLK_DIV_BANK_EDGE_STROBE_EN, pulse on each clk_o rise
// -----------------------------------------------------------------------------
module clk_div_channel
    import clk_div_bank_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DIV_W-1:0] ratio_i,
    input  logic             load_i,
    input  logic             enable_i,
    output logic             clk_o,
    output logic             ack_o,
    output logic             active_o
`ifdef CLK_DIV_BANK_EDGE_STROBE_EN
    , output logic           strobe_o
`endif
);

    ch_state_t            st_q, st_d;
    logic                 ack_q, ack_d;
    logic                 pend_eff;
    logic [DIV_W_MAX-1:0] pend_val;
    logic                 terminal;

    always_comb begin
        // A load in the same cycle as an apply point wins over an older
        // pending value, so the ack always carries the latest ratio.
        pend_eff = load_i | st_q.pending_flag;
        pend_val = load_i ? DIV_W_MAX'(ratio_i) : st_q.pending_ratio;
        terminal = (st_q.cnt == st_q.active_ratio);

        st_d               = st_q;
        st_d.pending_flag  = pend_eff;
        st_d.pending_ratio = pend_val;
        ack_d              = 1'b0;

        if (!st_q.active) begin
            // Idle: apply immediately so a simultaneous enable starts on the new ratio.
            if (pend_eff) begin
                st_d.active_ratio = pend_val;
                st_d.pending_flag = 1'b0;
                ack_d             = 1'b1;
            end
            if (enable_i) begin
                st_d.active = 1'b1;
                st_d.cnt    = '0;
                st_d.out_q  = 1'b0;
            end
        end else if (st_q.out_q) begin
            // High phase always runs to completion; disable and reload land on the fall.
            if (terminal) begin
                st_d.out_q = 1'b0;
                st_d.cnt   = '0;
                if (!enable_i)
                    st_d.active = 1'b0;
                if (pend_eff) begin
                    st_d.active_ratio = pend_val;
                    st_d.pending_flag = 1'b0;
                    ack_d             = 1'b1;
                end
            end else begin
                st_d.cnt = st_q.cnt + DIV_W_MAX'(1);
            end
        end else if (!enable_i) begin
            // Low phase: stopping now cannot produce a runt.
            st_d.active = 1'b0;
            st_d.cnt    = '0;
        end else if (terminal) begin
            st_d.out_q = 1'b1;
            st_d.cnt   = '0;
        end else begin
            st_d.cnt = st_q.cnt + DIV_W_MAX'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q  <= '0;
            ack_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            ack_q <= ack_d;
        end
    end

    assign clk_o    = st_q.out_q;
    assign ack_o    = ack_q;
    assign active_o = st_q.active;

`ifdef CLK_DIV_BANK_EDGE_STROBE_EN
    logic strobe_q, strobe_d;

    assign strobe_d = st_d.out_q & ~st_q.out_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            strobe_q <= 1'b0;
        else
            strobe_q <= strobe_d;
    end

    assign strobe_o = strobe_q;
`endif

endmodule

// File: rtl/clk_div_gate_bank.sv
// -----------------------------------------------------------------------------
// clk_div_gate_bank
// Bank of NUM_CH independent programmable clock dividers fed by one clock.
//   clock_input : the only clock
//   reset       : synchronous active-high reset
//   bus         : clk_div_gate_bank_if.slave (ratios, loads, enables in;
//                 divided clocks, load acks, active flags out)
// Optional: CLK_DIV_BANK_EDGE_STROBE_EN adds bus.rise_strobe.
// -----------------------------------------------------------------------------
module clk_div_gate_bank
    import clk_div_bank_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DIV_W  = DIV_W_DEF
) (
    input  logic                 clock_input,
    input  logic                 reset,
    clk_div_gate_bank_if.slave   bus
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        clk_div_channel #(
            .DIV_W (DIV_W)
        ) u_ch (
            .clk_i    (clock_input),
            .rst_i    (reset),
            .ratio_i  (bus.div_ratio[c*DIV_W +: DIV_W]),
            .load_i   (bus.div_load[c]),
            .enable_i (bus.ch_enable[c]),
            .clk_o    (bus.clock_output[c]),
            .ack_o    (bus.load_ack[c]),
            .active_o (bus.ch_active[c])
`ifdef CLK_DIV_BANK_EDGE_STROBE_EN
            , .strobe_o (bus.rise_strobe[c])
`endif
        );
    end

endmodule

// File: tb/tb_clk_div_gate_bank.sv
module tb_clk_div_gate_bank;
    localparam int NCH = 4;
    localparam int DW  = 8;

    logic clk;
    logic rst;

    clk_div_gate_bank_if #(.NUM_CH(NCH), .DIV_W(DW)) bus();

    clk_div_gate_bank #(.NUM_CH(NCH), .DIV_W(DW)) dut (
        .clock_input (clk),
        .reset       (rst),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs = 0;
    int chks = 0;
    int cyc  = 0;

    // Reference model: each running channel schedules its next toggle at an
    // absolute cycle number; pending ratio is -1 when none is waiting.
    bit m_act [NCH];
    bit m_lvl [NCH];
    bit m_ack [NCH];
    bit m_str [NCH];
    int m_ratio [NCH];
    int m_next  [NCH];
    int m_pend  [NCH];

    int rises [NCH];
    int acks  [NCH];
    int strb  [NCH];
    logic [NCH-1:0] prev_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            int r_in;
            r_in = int'(bus.div_ratio[c*DW +: DW]);
            m_ack[c] = 1'b0;
            m_str[c] = 1'b0;
            if (rst) begin
                m_act[c] = 1'b0; m_lvl[c] = 1'b0; m_ratio[c] = 0; m_pend[c] = -1;
            end else begin
                if (bus.div_load[c]) m_pend[c] = r_in;
                if (!m_act[c]) begin
                    if (m_pend[c] >= 0) begin
                        m_ratio[c] = m_pend[c]; m_pend[c] = -1; m_ack[c] = 1'b1;
                    end
                    if (bus.ch_enable[c]) begin
                        m_act[c] = 1'b1; m_lvl[c] = 1'b0; m_next[c] = cyc + m_ratio[c] + 1;
                    end
                end else if (m_lvl[c]) begin
                    if (cyc == m_next[c]) begin
                        m_lvl[c] = 1'b0;
                        if (!bus.ch_enable[c]) m_act[c] = 1'b0;
                        if (m_pend[c] >= 0) begin
                            m_ratio[c] = m_pend[c]; m_pend[c] = -1; m_ack[c] = 1'b1;
                        end
                        m_next[c] = cyc + m_ratio[c] + 1;
                    end
                end else if (!bus.ch_enable[c]) begin
                    m_act[c] = 1'b0;
                end else if (cyc == m_next[c]) begin
                    m_lvl[c] = 1'b1; m_str[c] = 1'b1; m_next[c] = cyc + m_ratio[c] + 1;
                end
            end
        end
    endtask

    task automatic tick();
        logic [NCH-1:0] e_out, e_ack, e_act, e_str;
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        for (int c = 0; c < NCH; c++) begin
            e_out[c] = m_lvl[c]; e_ack[c] = m_ack[c]; e_act[c] = m_act[c]; e_str[c] = m_str[c];
        end
        chk("clock_output", 32'(bus.clock_output), 32'(e_out));
        chk("load_ack", 32'(bus.load_ack), 32'(e_ack));
        chk("ch_active", 32'(bus.ch_active), 32'(e_act));
`ifdef CLK_DIV_BANK_EDGE_STROBE_EN
        chk("rise_strobe", 32'(bus.rise_strobe), 32'(e_str));
`endif
        for (int c = 0; c < NCH; c++) begin
            if (bus.clock_output[c] === 1'b1 && prev_out[c] === 1'b0) rises[c]++;
            if (bus.load_ack[c] === 1'b1) acks[c]++;
`ifdef CLK_DIV_BANK_EDGE_STROBE_EN
            if (bus.rise_strobe[c] === 1'b1) strb[c]++;
`endif
        end
        prev_out = bus.clock_output;
    endtask

    // Tick until clock_output[c] equals v; n = ticks taken. Timeout is a failed check.
    task automatic wait_lvl(input int c, input logic v, input int maxc, output int n);
        n = 0;
        while (bus.clock_output[c] !== v && n < maxc) begin
            tick();
            n++;
        end
        chk("wait_clock_output", 32'(bus.clock_output[c]), 32'(v));
    endtask

    task automatic set_ratio(input int c, input int r);
        logic [31:0] rv;
        rv = 32'(r);
        bus.div_ratio[c*DW +: DW] = rv[DW-1:0];
    endtask

    initial begin
        int n;
        int hi;
        for (int c = 0; c < NCH; c++) begin
            m_act[c] = 0; m_lvl[c] = 0; m_ack[c] = 0; m_str[c] = 0;
            m_ratio[c] = 0; m_next[c] = 0; m_pend[c] = -1;
            rises[c] = 0; acks[c] = 0; strb[c] = 0;
        end
        prev_out = '0;
        rst = 1'b1;
        bus.div_ratio = '0;
        bus.div_load  = '0;
        bus.ch_enable = '0;

        // Reset for 3 cycles, then idle for 20
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("idle_outputs", 32'({bus.clock_output, bus.load_ack, bus.ch_active}), 32'h0);

        // Ch0: load R=2 while idle, then enable
        set_ratio(0, 2);
        bus.div_load = 4'b0001;
        tick();
        chk("ch0_ack_latency", 32'(bus.load_ack[0]), 32'd1);
        bus.div_load = '0;
        bus.ch_enable[0] = 1'b1;
        tick();
        chk("ch0_active", 32'(bus.ch_active[0]), 32'd1);
        wait_lvl(0, 1'b1, 20, n);
        chk("ch0_first_rise", 32'(n), 32'd3);
        wait_lvl(0, 1'b0, 20, n);
        chk("ch0_high", 32'(n), 32'd3);
        wait_lvl(0, 1'b1, 20, n);
        chk("ch0_low", 32'(n), 32'd3);

        // Ch1 at R=3 (load and enable together), reload R=0 during a high phase
        set_ratio(1, 3);
        bus.div_load = 4'b0010;
        bus.ch_enable[1] = 1'b1;
        tick();
        chk("ch1_sim_ack", 32'(bus.load_ack[1]), 32'd1);
        bus.div_load = '0;
        wait_lvl(1, 1'b1, 20, n);
        chk("ch1_first_rise", 32'(n), 32'd4);
        tick();
        set_ratio(1, 0);
        bus.div_load = 4'b0010;
        tick();
        bus.div_load = '0;
        wait_lvl(1, 1'b0, 20, n);
        chk("ch1_high_full", 32'(n + 2), 32'd4);
        chk("ch1_ack_on_fall", 32'(bus.load_ack[1]), 32'd1);
        wait_lvl(1, 1'b1, 20, n);
        chk("ch1_r0_low", 32'(n), 32'd1);
        wait_lvl(1, 1'b0, 20, n);
        chk("ch1_r0_high", 32'(n), 32'd1);

        // Back to R=3, then two loads (1 then 5) inside one high phase
        set_ratio(1, 3);
        bus.div_load = 4'b0010;
        tick();
        bus.div_load = '0;
        n = 0;
        while (bus.load_ack[1] !== 1'b1 && n < 20) begin tick(); n++; end
        chk("ch1_reload_ack", 32'(bus.load_ack[1]), 32'd1);
        wait_lvl(1, 1'b1, 20, n);
        acks[1] = 0;
        tick();
        set_ratio(1, 1);
        bus.div_load = 4'b0010;
        tick();
        set_ratio(1, 5);
        tick();
        bus.div_load = '0;
        wait_lvl(1, 1'b0, 20, n);
        wait_lvl(1, 1'b1, 30, n);
        chk("ch1_r5_low", 32'(n), 32'd6);
        chk("ch1_single_ack", 32'(acks[1]), 32'd1);

        // Ch2 at R=4, disable one cycle into the high phase
        set_ratio(2, 4);
        bus.div_load = 4'b0100;
        bus.ch_enable[2] = 1'b1;
        tick();
        bus.div_load = '0;
        wait_lvl(2, 1'b1, 20, n);
        chk("ch2_first_rise", 32'(n), 32'd5);
        tick();
        bus.ch_enable[2] = 1'b0;
        wait_lvl(2, 1'b0, 20, n);
        chk("ch2_high_full", 32'(n + 1), 32'd5);
        chk("ch2_active_drop", 32'(bus.ch_active[2]), 32'd0);
        rises[2] = 0;
        repeat (15) tick();
        chk("ch2_no_toggle", 32'(rises[2]), 32'd0);

        // All channels at 0/1/2/7 enabled together, then reset
        bus.ch_enable = '0;
        n = 0;
        while (bus.ch_active !== '0 && n < 40) begin tick(); n++; end
        chk("all_stopped", 32'(bus.ch_active), 32'd0);
        set_ratio(0, 0); set_ratio(1, 1); set_ratio(2, 2); set_ratio(3, 7);
        bus.div_load = 4'b1111;
        tick();
        chk("all_acks", 32'(bus.load_ack), 32'hf);
        bus.div_load = '0;
        bus.ch_enable = 4'b1111;
        tick();
        for (int c = 0; c < NCH; c++) rises[c] = 0;
        repeat (32) tick();
        chk("rises_ch0", 32'(rises[0]), 32'd16);
        chk("rises_ch1", 32'(rises[1]), 32'd8);
        chk("rises_ch2", 32'(rises[2]), 32'd5);
        chk("rises_ch3", 32'(rises[3]), 32'd2);
        rst = 1'b1;
        tick();
        chk("reset_out", 32'(bus.clock_output), 32'd0);
        chk("reset_active", 32'(bus.ch_active), 32'd0);
        rst = 1'b0;
        bus.ch_enable = '0;
        tick();

`ifdef CLK_DIV_BANK_EDGE_STROBE_EN
        // Ch0 at R=1: strobe every 4 cycles
        set_ratio(0, 1);
        bus.div_load = 4'b0001;
        tick();
        bus.div_load = '0;
        bus.ch_enable[0] = 1'b1;
        tick();
        strb[0] = 0;
        repeat (16) tick();
        chk("strobe_count", 32'(strb[0]), 32'd4);
        bus.ch_enable = '0;
        repeat (6) tick();
`endif

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < NCH; c++) begin
                set_ratio(c, int'($urandom_range(0, 12)));
                bus.div_load[c] = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 9) == 0) bus.ch_enable[c] = ~bus.ch_enable[c];
            end
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        bus.div_load = '0;

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end
endmodule
